// File: rtl/depth_est_pkg.sv
// rtl/depth_est_pkg.sv - shared image geometry defaults and framer state encoding
package depth_est_pkg;

  localparam int DEF_IMG_WIDTH  = 64;
  localparam int DEF_IMG_HEIGHT = 48;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } framer_state_t;

endpackage

// File: rtl/frame_pos_counter.sv
// rtl/frame_pos_counter.sv - column/row position counter with line and frame wrap
module frame_pos_counter
  import depth_est_pkg::*;
#(
  parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
  parameter int IMG_HEIGHT = DEF_IMG_HEIGHT
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          en,
  input  logic                          clr,
  output logic [$clog2(IMG_WIDTH)-1:0]  col,
  output logic [$clog2(IMG_HEIGHT)-1:0] row,
  output logic                          last_col,
  output logic                          last_row
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

  assign last_col = (col == COL_LAST);
  assign last_row = (row == ROW_LAST);

  // clr together with en means the accepted pixel is pixel 0 of a fresh frame
  always_ff @(posedge clk) begin
    if (reset || (clr && !en)) begin
      col <= '0;
      row <= '0;
    end else if (clr && en) begin
      col <= CW'(1);
      row <= '0;
    end else if (en) begin
      if (last_col) begin
        col <= '0;
        row <= last_row ? '0 : row + RW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

endmodule

// File: rtl/stream_framer.sv
// rtl/stream_framer.sv - frames a raw pixel stream with line/frame markers and truncation detect
module stream_framer
  import depth_est_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
  parameter int IMG_HEIGHT = DEF_IMG_HEIGHT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  data_valid_i,
  input  logic                  frame_start_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  data_valid_o,
  output logic                  sop_o,
  output logic                  eop_o,
  output logic                  sof_o,
  output logic                  eof_o,
  output logic                  frame_err_o
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);

  framer_state_t state;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          last_col;
  logic          last_row;

  logic accept;
  logic eof_hit;
  logic restart;
  logic abort;
  logic first_col;
  logic first_row;

  // A frame start landing on the final pixel belongs to the next frame, not an abort
  assign eof_hit   = (state == ACTIVE) && data_valid_i && last_col && last_row;
  assign restart   = frame_start_i && !eof_hit;
  assign abort     = restart && (state == ACTIVE) && ((col != '0) || (row != '0));
  assign accept    = data_valid_i && ((state == ACTIVE) || frame_start_i);
  assign first_col = restart || (col == '0);
  assign first_row = restart || (row == '0);

  frame_pos_counter #(
    .IMG_WIDTH (IMG_WIDTH),
    .IMG_HEIGHT(IMG_HEIGHT)
  ) u_pos (
    .clk     (clk),
    .reset   (reset),
    .en      (accept),
    .clr     (restart),
    .col     (col),
    .row     (row),
    .last_col(last_col),
    .last_row(last_row)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      data_o       <= '0;
      data_valid_o <= 1'b0;
      sop_o        <= 1'b0;
      eop_o        <= 1'b0;
      sof_o        <= 1'b0;
      eof_o        <= 1'b0;
      frame_err_o  <= 1'b0;
    end else begin
      data_valid_o <= accept;
      if (accept) data_o <= data_i;
      sop_o       <= accept && first_col;
      sof_o       <= accept && first_col && first_row;
      eop_o       <= accept && !restart && last_col;
      eof_o       <= accept && !restart && last_col && last_row;
      frame_err_o <= abort;
      case (state)
        IDLE:    if (frame_start_i) state <= ACTIVE;
        ACTIVE:  if (eof_hit && !frame_start_i) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stream_framer.sv
// tb/tb_stream_framer.sv - directed self-checking bench for stream_framer at 4x3
module tb_stream_framer;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] data_i;
  logic       data_valid_i;
  logic       frame_start_i;
  logic [7:0] data_o;
  logic       data_valid_o;
  logic       sop_o, eop_o, sof_o, eof_o;
  logic       frame_err_o;

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] last_d;

  stream_framer #(
    .DATA_WIDTH(8),
    .IMG_WIDTH (4),
    .IMG_HEIGHT(3)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .data_i       (data_i),
    .data_valid_i (data_valid_i),
    .frame_start_i(frame_start_i),
    .data_o       (data_o),
    .data_valid_o (data_valid_o),
    .sop_o        (sop_o),
    .eop_o        (eop_o),
    .sof_o        (sof_o),
    .eof_o        (eof_o),
    .frame_err_o  (frame_err_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // expected {sop, eop, sof, eof} for pixel index within a 4x3 frame
  function automatic logic [3:0] flags(input int idx);
    flags = {idx % 4 == 0, idx % 4 == 3, idx == 0, idx == 11};
  endfunction

  // Apply one cycle of inputs at the falling edge, check registered outputs just after the rising edge
  task automatic cyc(input logic rst, input logic fs, input logic dv, input logic [7:0] d,
                     input string tag, input logic ev, input logic [7:0] ed,
                     input logic [3:0] ef, input logic ee);
    reset         = rst;
    frame_start_i = fs;
    data_valid_i  = dv;
    data_i        = d;
    @(posedge clk);
    #1;
    check({tag, ".valid"}, {31'd0, data_valid_o}, {31'd0, ev});
    check({tag, ".data"},  {24'd0, data_o}, {24'd0, ed});
    check({tag, ".flags"}, {28'd0, sop_o, eop_o, sof_o, eof_o}, {28'd0, ef});
    check({tag, ".err"},   {31'd0, frame_err_o}, {31'd0, ee});
    @(negedge clk);
  endtask

  task automatic pix(input logic fs, input logic [7:0] d, input int idx, input string tag);
    cyc(1'b0, fs, 1'b1, d, tag, 1'b1, d, flags(idx), 1'b0);
    last_d = d;
  endtask

  task automatic quiet(input logic fs, input logic dv, input logic [7:0] d, input logic ee,
                       input string tag);
    cyc(1'b0, fs, dv, d, tag, 1'b0, last_d, 4'b0000, ee);
  endtask

  initial begin
    reset = 1'b1; frame_start_i = 1'b0; data_valid_i = 1'b0; data_i = 8'h00;
    last_d = 8'h00;
    @(negedge clk);

    // reset state, with reset dominating concurrent stimulus
    cyc(1'b1, 1'b1, 1'b1, 8'hAA, "rst0", 1'b0, 8'h00, 4'b0000, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 8'h00, "rst1", 1'b0, 8'h00, 4'b0000, 1'b0);

    // pixels with no frame start are ignored
    for (int i = 0; i < 3; i++) quiet(1'b0, 1'b1, 8'h50 + 8'(i), 1'b0, "idle_drop");

    // nominal frame followed by 3 overrun pixels
    quiet(1'b1, 1'b0, 8'h00, 1'b0, "nom_fs");
    for (int i = 0; i < 12; i++) pix(1'b0, 8'(i), i, "nom");
    for (int i = 0; i < 3; i++) quiet(1'b0, 1'b1, 8'hE0 + 8'(i), 1'b0, "overrun");

    // gapped valid
    quiet(1'b1, 1'b0, 8'h00, 1'b0, "gap_fs");
    for (int i = 0; i < 12; i++) begin
      pix(1'b0, 8'h10 + 8'(i), i, "gap");
      quiet(1'b0, 1'b0, 8'hFF, 1'b0, "gap_idle");
    end

    // truncated frame after 6 pixels, then a full frame
    quiet(1'b1, 1'b0, 8'h00, 1'b0, "trc_fs0");
    for (int i = 0; i < 6; i++) pix(1'b0, 8'h40 + 8'(i), i, "trc_a");
    quiet(1'b1, 1'b0, 8'h00, 1'b1, "trc_fs1");
    for (int i = 0; i < 12; i++) pix(1'b0, 8'h48 + 8'(i), i, "trc_b");

    // frame start on last pixel and again on next pixel 0
    quiet(1'b1, 1'b0, 8'h00, 1'b0, "bnd_fs");
    for (int i = 0; i < 11; i++) pix(1'b0, 8'h20 + 8'(i), i, "bnd_a");
    pix(1'b1, 8'h2B, 11, "bnd_eof");
    pix(1'b1, 8'h30, 0, "bnd_sof");
    for (int i = 1; i < 12; i++) pix(1'b0, 8'h30 + 8'(i), i, "bnd_b");
    quiet(1'b0, 1'b1, 8'hEE, 1'b0, "bnd_after");

    // reset mid-frame after 5 pixels
    quiet(1'b1, 1'b0, 8'h00, 1'b0, "mrs_fs");
    for (int i = 0; i < 5; i++) pix(1'b0, 8'h60 + 8'(i), i, "mrs_a");
    cyc(1'b1, 1'b1, 1'b1, 8'h77, "mrs_rst", 1'b0, 8'h00, 4'b0000, 1'b0);
    last_d = 8'h00;
    quiet(1'b0, 1'b1, 8'h78, 1'b0, "mrs_drop");
    quiet(1'b1, 1'b0, 8'h00, 1'b0, "mrs_fs2");
    for (int i = 0; i < 12; i++) pix(1'b0, 8'h70 + 8'(i), i, "mrs_b");
    quiet(1'b0, 1'b0, 8'h00, 1'b0, "end");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/stream_framer.md
STREAM_FRAMER -- requirements
Module: stream_framer

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, pixel width in bits.
REQ-002 The block SHALL have parameter IMG_WIDTH, default 64, pixels per line (min 2).
REQ-003 The block SHALL have parameter IMG_HEIGHT, default 48, lines per frame (min 2).
REQ-004 The block SHALL have port clk  input  1  sole clock; all logic on its rising edge.
REQ-005 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 The block SHALL have port data_i  input  DATA_WIDTH  raw pixel from the capture source.
REQ-007 The block SHALL have port data_valid_i  input  1  data_i qualifier.
REQ-008 The block SHALL have port frame_start_i  input  1  one-cycle pulse marking the start of a new source frame.
REQ-009 The block SHALL have port data_o  output  DATA_WIDTH  framed pixel to conv_nn.
REQ-010 The block SHALL have port data_valid_o  output  1  data_o qualifier.
REQ-011 The block SHALL have ports sop_o, eop_o, sof_o, eof_o  output  1 each  first/last pixel of line, first/last pixel of frame.
REQ-012 The block SHALL have port frame_err_o  output  1  one-cycle pulse on a truncated frame.

Function
REQ-013 The block SHALL implement states IDLE, ACTIVE.
REQ-014 IDLE: data_valid_i SHALL be ignored; frame_start_i SHALL go to ACTIVE and clear col/row counters.
REQ-015 ACTIVE: each data_valid_i pixel SHALL be emitted exactly once on data_o with data_valid_o high, latency exactly 1 cycle.
REQ-016 sop_o SHALL equal data_valid_o && col==0; eop_o SHALL equal data_valid_o && col==IMG_WIDTH-1.
REQ-017 sof_o SHALL equal sop_o && row==0; eof_o SHALL equal eop_o && row==IMG_HEIGHT-1.
REQ-018 col SHALL increment per accepted pixel and wrap to 0 after IMG_WIDTH-1, incrementing row.
REQ-019 On the pixel producing eof_o the block SHALL return to IDLE; further valid pixels SHALL be dropped until the next frame_start_i.
REQ-020 frame_start_i in ACTIVE with counters non-zero SHALL pulse frame_err_o next cycle, clear counters, stay ACTIVE; no eof_o SHALL be emitted for the aborted frame.
REQ-021 frame_start_i and data_valid_i in the same cycle SHALL count that pixel as pixel 0 of the new frame (sof_o asserted).
REQ-022 frame_start_i coinciding with the last pixel of a frame SHALL emit that pixel with eof_o, no frame_err_o, and restart counting at 0 for the next frame.
REQ-023 All flag outputs SHALL be 0 whenever data_valid_o is 0; data_o SHALL hold its last value when data_valid_o is 0.
REQ-024 Counter widths SHALL be $clog2 of IMG_WIDTH and IMG_HEIGHT; no overflow beyond the wrap points.

Reset
REQ-025 reset SHALL force IDLE, col=row=0, data_o=0, data_valid_o=0, all flags 0, frame_err_o=0 on the next edge.
REQ-026 reset mid-frame SHALL discard the frame silently (no eof_o, no frame_err_o); the next frame_start_i SHALL start clean.
REQ-027 reset SHALL dominate frame_start_i and data_valid_i in the same cycle.

Structure
REQ-028 IMG_WIDTH, IMG_HEIGHT defaults and the state enum SHALL reside in shared package depth_est_pkg, also used by conv_nn sizing.
REQ-029 The col/row counter pair with wrap SHALL be sub-module frame_pos_counter (inputs en, clr; outputs col, row, last_col, last_row).
REQ-030 The block SHALL be instantiated upstream of conv_nn in FPGA_rtime_depth_estimation_top, driving its data/valid/sop/eop/sof/eof inputs.

Verification (IMG_WIDTH=4, IMG_HEIGHT=3)
REQ-031 Nominal: frame_start_i then 12 contiguous pixels 0x00..0x0B -> outputs 1 cycle later; sof_o on 0x00, sop_o on 0x00/0x04/0x08, eop_o on 0x03/0x07/0x0B, eof_o on 0x0B only.
REQ-032 Gapped valid: same 12 pixels with data_valid_i toggling every cycle -> identical flag/pixel sequence, flags never high with data_valid_o low.
REQ-033 Truncation: frame_start_i after 6 pixels, then 12 pixels -> frame_err_o one pulse, no eof_o for first frame, second frame fully framed with sof_o on its first pixel.
REQ-034 Overrun/idle: 15 pixels after one frame_start_i -> 12 emitted, eof_o on 12th, last 3 dropped; pixels with no prior frame_start_i after reset -> nothing emitted.
REQ-035 Boundary: frame_start_i concurrent with pixel 12 (eof) and with next pixel 0 -> eof_o then sof_o, no frame_err_o.
REQ-036 Reset mid-frame after 5 pixels -> all outputs 0 next cycle, no frame_err_o; next frame_start_i + 12 pixels framed normally.
